// File: rtl/mul_i8_rr_arbiter.sv
// Round-robin front end sharing one external 8-bit multiplier among NREQ requesters.
// Define MUL_ARB_PRIO_EN to give requester 0 fixed highest priority.
module mul_i8_rr_arbiter #(
    parameter int unsigned NREQ    = 4,
    parameter int unsigned MUL_LAT = 2
) (
    input  logic              clock,
    input  logic              reset,
    input  logic [NREQ-1:0]   req_valid,
    output logic [NREQ-1:0]   req_ready,
    input  logic [8*NREQ-1:0] req_a,
    input  logic [8*NREQ-1:0] req_b,
    output logic              mul_valid,
    output logic [7:0]        mul_a,
    output logic [7:0]        mul_b,
    input  logic [7:0]        mul_y,
    output logic [NREQ-1:0]   rsp_valid,
    output logic [7:0]        rsp_y,
    output logic [NREQ-1:0]   busy
);
    localparam int unsigned IDW = $clog2(NREQ);

    logic [IDW-1:0]     ptr_q, ptr_d;
    logic [NREQ-1:0]    busy_q, busy_d;
    logic               mul_valid_q, mul_valid_d;
    logic [7:0]         mul_a_q, mul_a_d;
    logic [7:0]         mul_b_q, mul_b_d;
    logic [NREQ-1:0]    rsp_valid_q, rsp_valid_d;
    logic [7:0]         rsp_y_q, rsp_y_d;
    logic [MUL_LAT-1:0] tag_v_q, tag_v_d;
    logic [IDW-1:0]     tag_id_q [MUL_LAT];
    logic [IDW-1:0]     tag_id_d [MUL_LAT];

    logic [NREQ-1:0]    eligible;
    logic               grant_found;
    logic [IDW-1:0]     grant_id;
    logic [IDW-1:0]     scan_id;
    logic [IDW+2:0]     slice_lsb;

    assign eligible  = req_valid & ~busy_q;
    assign slice_lsb = {grant_id, 3'b000};

    always_comb begin
        grant_found = 1'b0;
        grant_id    = '0;
        scan_id     = '0;
        for (int unsigned k = 0; k < NREQ; k++) begin
            scan_id = IDW'((32'(ptr_q) + k) % NREQ);
            if (!grant_found && eligible[scan_id]) begin
                grant_found = 1'b1;
                grant_id    = scan_id;
            end
        end
`ifdef MUL_ARB_PRIO_EN
        if (eligible[0]) begin
            grant_found = 1'b1;
            grant_id    = '0;
        end
`endif
        // Suppress grants while held in reset so req_ready reads 0 there.
        if (!reset) begin
            grant_found = 1'b0;
        end
    end

    always_comb begin
        req_ready = '0;
        if (grant_found) begin
            req_ready[grant_id] = 1'b1;
        end
    end

    always_comb begin
        ptr_d       = ptr_q;
        mul_valid_d = grant_found;
        mul_a_d     = mul_a_q;
        mul_b_d     = mul_b_q;
        // A requester stays busy through its response cycle.
        busy_d      = busy_q & ~rsp_valid_q;
        if (grant_found) begin
            mul_a_d          = req_a[slice_lsb +: 8];
            mul_b_d          = req_b[slice_lsb +: 8];
            busy_d[grant_id] = 1'b1;
            ptr_d            = (grant_id == IDW'(NREQ - 1)) ? '0 : grant_id + IDW'(1);
`ifdef MUL_ARB_PRIO_EN
            if (grant_id == '0) begin
                ptr_d = ptr_q;
            end
`endif
        end

        tag_v_d     = '0;
        tag_id_d    = '{default: '0};
        tag_v_d[0]  = grant_found;
        tag_id_d[0] = grant_id;
        for (int unsigned i = 1; i < MUL_LAT; i++) begin
            tag_v_d[i]  = tag_v_q[i-1];
            tag_id_d[i] = tag_id_q[i-1];
        end

        rsp_valid_d = '0;
        rsp_y_d     = rsp_y_q;
        if (tag_v_q[MUL_LAT-1]) begin
            rsp_valid_d[tag_id_q[MUL_LAT-1]] = 1'b1;
            rsp_y_d                          = mul_y;
        end
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            ptr_q       <= '0;
            busy_q      <= '0;
            mul_valid_q <= 1'b0;
            mul_a_q     <= '0;
            mul_b_q     <= '0;
            rsp_valid_q <= '0;
            rsp_y_q     <= '0;
            tag_v_q     <= '0;
            tag_id_q    <= '{default: '0};
        end else begin
            ptr_q       <= ptr_d;
            busy_q      <= busy_d;
            mul_valid_q <= mul_valid_d;
            mul_a_q     <= mul_a_d;
            mul_b_q     <= mul_b_d;
            rsp_valid_q <= rsp_valid_d;
            rsp_y_q     <= rsp_y_d;
            tag_v_q     <= tag_v_d;
            tag_id_q    <= tag_id_d;
        end
    end

    assign mul_valid = mul_valid_q;
    assign mul_a     = mul_a_q;
    assign mul_b     = mul_b_q;
    assign rsp_valid = rsp_valid_q;
    assign rsp_y     = rsp_y_q;
    assign busy      = busy_q;

endmodule

// File: tb/tb_mul_i8_rr_arbiter.sv
// Directed bench for mul_i8_rr_arbiter with a registered external multiplier model.
// Expectations follow MUL_ARB_PRIO_EN when the bench is built with it defined.
module tb_mul_i8_rr_arbiter;
    localparam int unsigned NREQ    = 4;
    localparam int unsigned MUL_LAT = 2;

    logic              clock = 1'b0;
    logic              reset = 1'b0;
    logic [NREQ-1:0]   req_valid = '0;
    logic [NREQ-1:0]   req_ready;
    logic [8*NREQ-1:0] req_a = '0;
    logic [8*NREQ-1:0] req_b = '0;
    logic              mul_valid;
    logic [7:0]        mul_a;
    logic [7:0]        mul_b;
    logic [7:0]        mul_y;
    logic [NREQ-1:0]   rsp_valid;
    logic [7:0]        rsp_y;
    logic [NREQ-1:0]   busy;

    int n_checks = 0;
    int n_errors = 0;

    mul_i8_rr_arbiter #(
        .NREQ    (NREQ),
        .MUL_LAT (MUL_LAT)
    ) dut (
        .clock     (clock),
        .reset     (reset),
        .req_valid (req_valid),
        .req_ready (req_ready),
        .req_a     (req_a),
        .req_b     (req_b),
        .mul_valid (mul_valid),
        .mul_a     (mul_a),
        .mul_b     (mul_b),
        .mul_y     (mul_y),
        .rsp_valid (rsp_valid),
        .rsp_y     (rsp_y),
        .busy      (busy)
    );

    always #5 clock = ~clock;

    // The DUT's operand register is the first multiplier stage; this is the second.
    always_ff @(posedge clock) mul_y <= mul_a * mul_b;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clock);
        #2;
    endtask

    task automatic set_req(input int i, input logic v, input logic [7:0] a, input logic [7:0] b);
        req_valid[i]    = v;
        req_a[8*i +: 8] = a;
        req_b[8*i +: 8] = b;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog timeout");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [3:0]  exp_ready;
        logic [3:0]  exp_rsp;
        logic [3:0]  exp_c0;
        logic [3:0]  exp_c1;
        logic [7:0]  t3_a [3];
        logic [7:0]  t3_b [3];
        logic [7:0]  t3_y [3];

        t3_a = '{8'd16, 8'd200, 8'd255};
        t3_b = '{8'd16, 8'd3,   8'd255};
        t3_y = '{8'd0,  8'd88,  8'd1};

        // Reset state
        tick();
        tick();
        #1;
        check("rst_ready", 32'(req_ready), 0);
        check("rst_mul_valid", 32'(mul_valid), 0);
        check("rst_mul_a", 32'(mul_a), 0);
        check("rst_rsp_valid", 32'(rsp_valid), 0);
        check("rst_rsp_y", 32'(rsp_y), 0);
        check("rst_busy", 32'(busy), 0);
        reset = 1'b1;
        tick();

        // Test 1: single op 9*3 from requester 0
        set_req(0, 1'b1, 8'd9, 8'd3);
        #1;
        check("t1_ready", 32'(req_ready), 32'h1);
        check("t1_busy0", 32'(busy), 0);
        tick();
        set_req(0, 1'b0, 8'd0, 8'd0);
        for (int c = 1; c <= 4; c++) begin
            #1;
            check("t1_busy", 32'(busy), (c <= 3) ? 32'h1 : 32'h0);
            check("t1_rsp", 32'(rsp_valid), (c == 3) ? 32'h1 : 32'h0);
            if (c == 3) check("t1_y", 32'(rsp_y), 27);
            if (c == 1) begin
                check("t1_mul_valid", 32'(mul_valid), 1);
                check("t1_mul_a", 32'(mul_a), 9);
                check("t1_mul_b", 32'(mul_b), 3);
            end
            if (c == 2) check("t1_mul_idle", 32'(mul_valid), 0);
            tick();
        end

        // Test 2: all four valid straight out of reset
        reset = 1'b0;
        #1;
        reset = 1'b1;
        for (int c = 0; c < 8; c++) begin
            for (int i = 0; i < 4; i++) set_req(i, c < 4, 8'(i + 1), 8'd10);
            #1;
            exp_ready = (c < 4) ? 4'(1 << c) : 4'b0;
            exp_rsp   = (c >= 3 && c < 7) ? 4'(1 << (c - 3)) : 4'b0;
            check("t2_ready", 32'(req_ready), 32'(exp_ready));
            check("t2_rsp", 32'(rsp_valid), 32'(exp_rsp));
            if (c >= 3 && c < 7) check("t2_y", 32'(rsp_y), 32'((c - 2) * 10));
            tick();
        end

        // Test 3: products that wrap modulo 256
        for (int c = 0; c < 7; c++) begin
            for (int i = 0; i < 3; i++) set_req(i, c < 3, t3_a[i], t3_b[i]);
            #1;
            exp_ready = (c < 3) ? 4'(1 << c) : 4'b0;
            exp_rsp   = (c >= 3 && c < 6) ? 4'(1 << (c - 3)) : 4'b0;
            check("t3_ready", 32'(req_ready), 32'(exp_ready));
            check("t3_rsp", 32'(rsp_valid), 32'(exp_rsp));
            if (c >= 3 && c < 6) check("t3_y", 32'(rsp_y), 32'(t3_y[c-3]));
            tick();
        end

        // Test 4: requester 1 holds valid; regranted the cycle after its response
        for (int c = 0; c < 9; c++) begin
            set_req(1, c < 5, 8'd7, 8'd6);
            #1;
            check("t4_ready", 32'(req_ready), (c == 0 || c == 4) ? 32'h2 : 32'h0);
            check("t4_busy", 32'(busy),
                  ((c >= 1 && c <= 3) || (c >= 5 && c <= 7)) ? 32'h2 : 32'h0);
            check("t4_rsp", 32'(rsp_valid), (c == 3 || c == 7) ? 32'h2 : 32'h0);
            if (c == 3 || c == 7) check("t4_y", 32'(rsp_y), 42);
            tick();
        end

        // Test 6: requesters 0 and 2 valid with the pointer at 2
`ifdef MUL_ARB_PRIO_EN
        exp_c0 = 4'b0001;
        exp_c1 = 4'b0100;
`else
        exp_c0 = 4'b0100;
        exp_c1 = 4'b0001;
`endif
        set_req(0, 1'b1, 8'd5, 8'd5);
        set_req(2, 1'b1, 8'd11, 8'd2);
        #1;
        check("t6_first", 32'(req_ready), 32'(exp_c0));
        tick();
        #1;
        check("t6_second", 32'(req_ready), 32'(exp_c1));
        tick();

        // Test 5: reset with two ops in flight, requesters still asserting valid
        reset = 1'b0;
        #1;
        check("t5_ready", 32'(req_ready), 0);
        check("t5_mul_valid", 32'(mul_valid), 0);
        check("t5_mul_a", 32'(mul_a), 0);
        check("t5_mul_b", 32'(mul_b), 0);
        check("t5_rsp", 32'(rsp_valid), 0);
        check("t5_rsp_y", 32'(rsp_y), 0);
        check("t5_busy", 32'(busy), 0);
        tick();
        tick();
        req_valid = '0;
        reset     = 1'b1;
        for (int c = 0; c < 6; c++) begin
            #1;
            check("t5_no_rsp", 32'(rsp_valid), 0);
            check("t5_idle_busy", 32'(busy), 0);
            tick();
        end
        for (int i = 0; i < 4; i++) set_req(i, 1'b1, 8'd1, 8'd1);
        #1;
        check("t5_grant0", 32'(req_ready), 32'h1);
        tick();
        req_valid = '0;
        repeat (5) tick();

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
